// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS cores: opcodes, functs, ALU codes, mux encodings, control FSM states.
package mips_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned STATE_W    = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_ERR    = 4'd13
  } state_t;

  // Moore part of the control word, registered alongside the state.
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the main-control aluop and the R-type funct field to the ALU operation code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0]            aluop,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and traps illegal ops.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       op,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  instr_done,
  output logic                  illegal_op
);

  state_t                  state, state_d;
  ctrl_t                   ctrl_d, ctrl_q;
  logic [1:0]              aluop_d;
  logic                    alu_use_d;
  logic [ALU_CTRL_W-1:0]   alu_dec, alu_ctrl_q;
  logic                    rdy;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .aluop    (aluop_d),
    .funct    (funct),
    .alu_ctrl (alu_dec)
  );

  // Next state, then the Moore control word of the state being entered.
  always_comb begin
    state_d   = state;
    ctrl_d    = '0;
    aluop_d   = ALUOP_ADD;
    alu_use_d = 1'b0;

    case (state)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = funct_legal(funct) ? S_EXEC : S_ERR;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ERR;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        alu_use_d        = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMM_SH;
        alu_use_d        = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        alu_use_d        = 1'b1;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_RT;
        aluop_d          = ALUOP_FUNCT;
        alu_use_d        = 1'b1;
      end
      S_ALUWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_src_b  = SRCB_RT;
        ctrl_d.pc_src     = PC_ALUOUT;
        ctrl_d.instr_done = 1'b1;
        aluop_d           = ALUOP_SUB;
        alu_use_d         = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_src     = PC_JUMP;
        ctrl_d.pc_en      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_ERR:   ctrl_d.illegal_op = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
    end else begin
      state      <= state_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_use_d ? alu_dec : ALU_CTRL_W'(0);
    end
  end

  // Handshake-qualified strobes act in the same cycle as the input they depend on.
  assign ir_write   = (state == S_FETCH) && rdy;
  assign pc_en      = ctrl_q.pc_en || ir_write || ((state == S_BRANCH) && zero);
  assign instr_done = ctrl_q.instr_done || ((state == S_MEMWR) && rdy);

  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_ctrl   = alu_ctrl_q;
  assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected cycle lists checked every cycle.
module tb_mips_multicycle_ctrl;

  logic       clk, rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [17:0] obs;

  int tests = 0;
  int fails = 0;

  mips_multicycle_ctrl #(.MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign obs = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_ctrl, instr_done, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rdy;
    logic        z;
    logic [17:0] exp;
    string       tag;
  } step_t;

  step_t q[$];

  function automatic logic [17:0] o(logic pe, logic [1:0] ps, logic io, logic mr, logic mw,
                                    logic irw, logic rd, logic m2r, logic rw, logic asa,
                                    logic [1:0] asb, logic [2:0] ac, logic dn, logic il);
    return {pe, ps, io, mr, mw, irw, rd, m2r, rw, asa, asb, ac, dn, il};
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit legal_r(logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A;
  endfunction

  function automatic bit legal_op(logic [5:0] p);
    return p == 6'b000000 || p == 6'b100011 || p == 6'b101011 || p == 6'b000100 ||
           p == 6'b001000 || p == 6'b000010;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(logic rdy, logic z, logic [17:0] e, string tag);
    step_t s;
    s.rdy = rdy; s.z = z; s.exp = e; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic check(logic [17:0] e, string tag);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, e, $time);
    end
  endtask

  // Expected cycle list for one instruction; mem_ready/zero are randomised where they must not matter.
  task automatic build(logic [5:0] p, logic [5:0] f, logic z, int fw, int mw);
    for (int i = 0; i < fw; i++) push(1'b0, rb(), o(0,0,0,1,0,0,0,0,0,0,2'b01,3'b010,0,0), "fetch_wait");
    push(1'b1, rb(), o(1,0,0,1,0,1,0,0,0,0,2'b01,3'b010,0,0), "fetch");
    push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010,0,0), "decode");
    if (p == 6'b000000 && legal_r(f)) begin
      push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,2'b00,alu_of(f),0,0), "exec");
      push(rb(), rb(), o(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,1,0), "aluwb");
    end else if (p == 6'b100011) begin
      push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,0), "lw_adr");
      for (int i = 0; i < mw; i++) push(1'b0, rb(), o(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,0,0), "memrd_wait");
      push(1'b1, rb(), o(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,0,0), "memrd");
      push(rb(), rb(), o(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,1,0), "memwb");
    end else if (p == 6'b101011) begin
      push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,0), "sw_adr");
      for (int i = 0; i < mw; i++) push(1'b0, rb(), o(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,0,0), "memwr_wait");
      push(1'b1, rb(), o(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,1,0), "memwr");
    end else if (p == 6'b000100) begin
      push(rb(), z, o(z,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b110,1,0), "branch");
    end else if (p == 6'b001000) begin
      push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,0), "addiex");
      push(rb(), rb(), o(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,1,0), "addiwb");
    end else if (p == 6'b000010) begin
      push(rb(), rb(), o(1,2'b10,0,0,0,0,0,0,0,0,2'b00,3'b000,1,0), "jump");
    end else begin
      for (int i = 0; i < 20; i++) push(rb(), rb(), o(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,0,1), "err");
    end
  endtask

  task automatic run_q(int n);
    step_t s;
    int k = 0;
    while (q.size() > 0 && k < n) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      zero      = s.z;
      #1;
      check(s.exp, s.tag);
      k++;
    end
    q.delete();
  endtask

  task automatic run_instr(logic [5:0] p, logic [5:0] f, logic z, int fw, int mw);
    op = p; funct = f;
    build(p, f, z, fw, mw);
    run_q(1000);
  endtask

  // Asynchronous reset mid-cycle, then one IDLE cycle after release.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check(18'h0, "rst_async");
    @(negedge clk);
    mem_ready = rb(); zero = rb();
    #1;
    check(18'h0, "rst_hold");
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rb();
    #1;
    check(18'h0, "idle");
  endtask

  logic [5:0] rfn [5];
  logic [5:0] p, f;
  int cls;

  initial begin
    rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h2A;
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'h0; funct = 6'h0;
    do_reset();

    run_instr(6'b000000, 6'h20, 1'b0, 0, 0);   // add
    run_instr(6'b100011, 6'h3F, 1'b0, 0, 3);   // lw, 3 wait cycles in MEMRD
    run_instr(6'b000100, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b000000, 6'h22, 1'b0, 2, 0);   // sub with 2 fetch waits
    run_instr(6'b101011, 6'h11, 1'b0, 0, 2);   // sw
    run_instr(6'b001000, 6'h05, 1'b0, 1, 0);   // addi
    run_instr(6'b000010, 6'h00, 1'b0, 0, 0);   // j

    run_instr(6'b111111, 6'h20, 1'b0, 0, 0);   // illegal op, sticky ERR
    do_reset();

    op = 6'b101011; funct = 6'h00;              // reset while sw waits in MEMWR
    build(op, funct, 1'b0, 0, 5);
    run_q(5);
    do_reset();

    run_instr(6'b000000, 6'h2A, 1'b0, 0, 0);   // slt after restart

    for (int n = 0; n < 60; n++) begin
      cls = int'($urandom_range(0, 5));
      f = 6'($urandom_range(0, 63));
      case (cls)
        0: begin p = 6'b000000; f = rfn[$urandom_range(0, 4)]; end
        1: p = 6'b100011;
        2: p = 6'b101011;
        3: p = 6'b000100;
        4: p = 6'b001000;
        default: p = 6'b000010;
      endcase
      run_instr(p, f, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Random illegal encodings: unsupported op or R-type with unsupported funct.
    for (int n = 0; n < 3; n++) begin
      if (rb()) begin
        p = 6'b000000;
        do f = 6'($urandom_range(0, 63)); while (legal_r(f));
      end else begin
        do p = 6'($urandom_range(0, 63)); while (legal_op(p));
        f = 6'($urandom_range(0, 63));
      end
      run_instr(p, f, 1'b0, int'($urandom_range(0, 1)), 0);
      do_reset();
    end

    run_instr(6'b000000, 6'h25, 1'b0, 0, 0);   // or

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
